// File: rtl/layer0_input_queue.sv
// ============================================================================
// layer0_input_queue
//
// Purpose:
//   Streams one image frame pixel by pixel, thresholds every pixel, and pushes
//   the index of each active pixel into an internal first-word-fall-through
//   FIFO. The Layer 1 controller then drains the FIFO. Only one frame is held
//   at a time: a new frame is accepted after the previous one has drained.
//
// Ports:
//   clk          in   clock, all state updates on the rising edge
//   reset        in   asynchronous, active-high reset
//   pixelValid   in   pixelIn carries a sample this cycle
//   pixelIn      in   pixel sample, raster order, index 0 first
//   pixelReady   out  block accepts a pixel this cycle (LOAD state)
//   dequeue      in   pop the FIFO head on this rising edge
//   inputsReady  out  frame fully loaded, queue contents final (DRAIN state)
//   queueEmpty   out  FIFO holds zero entries
//   queueOut     out  FIFO head index, meaningful only while queueEmpty = 0
//   emptyFrame   out  one-cycle pulse after a frame with no active pixels
//   activeCount  out  current FIFO occupancy
//
// Handshake: a pixel transfers on a rising edge where pixelValid and
// pixelReady are both high; a pop happens on a rising edge where dequeue is
// high, inputsReady is high and queueEmpty is low. Any other dequeue is
// ignored.
//
// The FSM state is fully visible on pixelReady / inputsReady, which are
// mutually exclusive one-hot decodes of LOAD / DRAIN.
// ============================================================================
module layer0_input_queue #(
    parameter int PIXEL_WIDTH = 8,
    parameter int THRESHOLD   = 128,
    parameter int NUM_PIXELS  = 784,
    parameter int ADDR_WIDTH  = 10    // FIFO depth 2**ADDR_WIDTH must cover NUM_PIXELS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pixelValid,
    input  logic [PIXEL_WIDTH-1:0] pixelIn,
    output logic                   pixelReady,
    input  logic                   dequeue,
    output logic                   inputsReady,
    output logic                   queueEmpty,
    output logic [ADDR_WIDTH-1:0]  queueOut,
    output logic                   emptyFrame,
    output logic [ADDR_WIDTH:0]    activeCount
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [ADDR_WIDTH-1:0]  LAST_IDX = ADDR_WIDTH'(NUM_PIXELS - 1);
    localparam logic [PIXEL_WIDTH-1:0] THRESH   = PIXEL_WIDTH'(THRESHOLD);
    localparam logic [ADDR_WIDTH-1:0]  PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]    CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t                  state_q,        state_d;
    logic [ADDR_WIDTH-1:0]   pixel_count_q,  pixel_count_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q,       wr_ptr_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q,       rd_ptr_d;
    logic [ADDR_WIDTH:0]     count_q,        count_d;
    logic                    empty_frame_q,  empty_frame_d;
    logic                    pixel_ready_q,  pixel_ready_d;
    logic                    inputs_ready_q, inputs_ready_d;

    logic [ADDR_WIDTH-1:0]   mem [DEPTH];

    logic accept;
    logic push;
    logic pop;
    logic last_pixel;

    // Pixel acceptance and pops are gated by the registered state only, so no
    // input reaches an output combinationally.
    assign accept     = pixelValid && (state_q == ST_LOAD);
    assign push       = accept && (pixelIn >= THRESH);
    assign last_pixel = accept && (pixel_count_q == LAST_IDX);
    assign pop        = dequeue && (state_q == ST_DRAIN) && (count_q != '0);

    always_comb begin
        state_d        = state_q;
        pixel_count_d  = pixel_count_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        empty_frame_d  = 1'b0;

        // Push (LOAD only) and pop (DRAIN only) are mutually exclusive.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            count_d  = count_q + CNT_ONE;
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            count_d  = count_q - CNT_ONE;
        end

        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    if (last_pixel) begin
                        pixel_count_d = '0;
                        // Decide on the post-edge occupancy so a frame whose
                        // only active pixel is the last one still drains.
                        if (count_d != '0) begin
                            state_d = ST_DRAIN;
                        end else begin
                            empty_frame_d = 1'b1;
                        end
                    end else begin
                        pixel_count_d = pixel_count_q + PTR_ONE;
                    end
                end
            end
            ST_DRAIN: begin
                // The pop that empties the queue also releases the next frame,
                // so inputsReady and queueEmpty change on the same edge.
                if (pop && (count_q == CNT_ONE)) begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        pixel_ready_d  = (state_d == ST_LOAD);
        inputs_ready_d = (state_d == ST_DRAIN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_LOAD;
            pixel_count_q  <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            empty_frame_q  <= 1'b0;
            pixel_ready_q  <= 1'b1;
            inputs_ready_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pixel_count_q  <= pixel_count_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            empty_frame_q  <= empty_frame_d;
            pixel_ready_q  <= pixel_ready_d;
            inputs_ready_q <= inputs_ready_d;
        end
    end

    // Storage array carries no reset; stale entries are never exposed because
    // queueOut is only meaningful while the queue is non-empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= pixel_count_q;
        end
    end

    assign pixelReady  = pixel_ready_q;
    assign inputsReady = inputs_ready_q;
    assign emptyFrame  = empty_frame_q;
    assign activeCount = count_q;
    assign queueEmpty  = (count_q == '0);
    assign queueOut    = mem[rd_ptr_q];

endmodule

// File: tb/tb_layer0_input_queue.sv
module tb_layer0_input_queue;

  localparam int PW = 8;
  localparam int AW = 10;
  localparam int NP = 784;
  localparam int TH = 128;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          pixel_valid = 1'b0;
  logic [PW-1:0] pixel_in = '0;
  logic          dequeue = 1'b0;
  logic          pixel_ready;
  logic          inputs_ready;
  logic          queue_empty;
  logic [AW-1:0] queue_out;
  logic          empty_frame;
  logic [AW:0]   active_count;

  layer0_input_queue #(
    .PIXEL_WIDTH(PW), .THRESHOLD(TH), .NUM_PIXELS(NP), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset),
    .pixelValid(pixel_valid), .pixelIn(pixel_in), .pixelReady(pixel_ready),
    .dequeue(dequeue), .inputsReady(inputs_ready), .queueEmpty(queue_empty),
    .queueOut(queue_out), .emptyFrame(empty_frame), .activeCount(active_count)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A frame is a list of indices whose pixel reached the threshold; the
  // list is handed over once the whole frame has arrived and is consumed
  // in arrival order.
  logic [AW-1:0] exp_q[$];
  int m_idx = 0;
  bit m_loaded = 0;
  bit m_empty_pulse = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      m_idx = 0;
      m_loaded = 0;
      m_empty_pulse = 0;
    end else begin
      m_empty_pulse = 0;
      if (!m_loaded) begin
        if (pixel_valid) begin
          if (int'(pixel_in) >= TH) exp_q.push_back(AW'(m_idx));
          if (m_idx == NP - 1) begin
            m_idx = 0;
            if (exp_q.size() > 0) m_loaded = 1;
            else m_empty_pulse = 1;
          end else begin
            m_idx++;
          end
        end
      end else if (dequeue && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) m_loaded = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("pixelReady", int'(pixel_ready), int'(!m_loaded));
    chk("inputsReady", int'(inputs_ready), int'(m_loaded));
    chk("queueEmpty", int'(queue_empty), int'(exp_q.size() == 0));
    chk("activeCount", int'(active_count), exp_q.size());
    chk("emptyFrame", int'(empty_frame), int'(m_empty_pulse));
    if (exp_q.size() > 0) chk("queueOut", int'(queue_out), int'(exp_q[0]));
  end

  // ---------------- driver tasks ----------------
  // mode 0: all zero, 1: all 255, 2: random, 3: only pixel 5 = 200,
  // 4: pixel 10 = 127 / 11 = 128, 5: ten active pixels at i%80==3
  function automatic logic [PW-1:0] pix_val(input int mode, input int i);
    case (mode)
      0: return '0;
      1: return 8'd255;
      2: return PW'($urandom_range(0, 255));
      3: return (i == 5) ? 8'd200 : 8'd0;
      4: begin
        if (i == 10) return 8'd127;
        if (i == 11) return 8'd128;
        return PW'($urandom_range(0, 127));
      end
      default: return (i % 80 == 3) ? PW'($urandom_range(128, 255))
                                     : PW'($urandom_range(0, 127));
    endcase
  endfunction

  task automatic send_frame(input int mode, input int n);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        pixel_valid = 1'b0;
        pixel_in = PW'($urandom_range(0, 255));
        dequeue = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      pixel_valid = 1'b1;
      pixel_in = pix_val(mode, i);
      dequeue = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    pixel_valid = 1'b0;
    dequeue = 1'b0;
  endtask

  task automatic drain(input int max_pops, input bit check_seq, input bit gaps);
    int pops = 0;
    int cycles = 0;
    while (inputs_ready && pops < max_pops && cycles < 5000) begin
      dequeue = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      pixel_valid = 1'($urandom_range(0, 1));
      pixel_in = PW'($urandom_range(0, 255));
      if (dequeue && check_seq) chk("drain_order", int'(queue_out), pops);
      if (dequeue) pops++;
      @(posedge clk); #1;
      cycles++;
    end
    if (cycles >= 5000) chk("drain_timeout", cycles, 0);
    dequeue = 1'b0;
    pixel_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_pixelReady"}, int'(pixel_ready), 1);
    chk({tag, "_inputsReady"}, int'(inputs_ready), 0);
    chk({tag, "_queueEmpty"}, int'(queue_empty), 1);
    chk({tag, "_emptyFrame"}, int'(empty_frame), 0);
    chk({tag, "_activeCount"}, int'(active_count), 0);
  endtask

  task automatic reset_pulse(input string tag);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_values(tag);
    reset = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // single active pixel
    send_frame(3, NP);
    chk("single_inputsReady", int'(inputs_ready), 1);
    chk("single_pixelReady", int'(pixel_ready), 0);
    chk("single_queueOut", int'(queue_out), 5);
    chk("single_activeCount", int'(active_count), 1);
    drain(1, 1'b0, 1'b0);
    chk("single_pop_queueEmpty", int'(queue_empty), 1);
    chk("single_pop_inputsReady", int'(inputs_ready), 0);
    chk("single_pop_pixelReady", int'(pixel_ready), 1);

    // dequeue while empty in LOAD is ignored
    dequeue = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    dequeue = 1'b0;
    chk("ignored_deq_count", int'(active_count), 0);
    chk("ignored_deq_empty", int'(queue_empty), 1);

    // threshold boundary
    send_frame(4, NP);
    chk("thresh_activeCount", int'(active_count), 1);
    chk("thresh_queueOut", int'(queue_out), 11);
    drain(2000, 1'b0, 1'b1);

    // full frames, second one wraps the pointers
    send_frame(1, NP);
    chk("full1_activeCount", int'(active_count), NP);
    drain(NP, 1'b1, 1'b1);
    chk("full1_drained", int'(queue_empty), 1);
    send_frame(1, NP);
    chk("full2_activeCount", int'(active_count), NP);
    drain(NP, 1'b1, 1'b0);
    chk("full2_drained", int'(inputs_ready), 0);

    // zero-active frame, then next frame accepted immediately
    send_frame(0, NP);
    chk("zero_emptyFrame", int'(empty_frame), 1);
    chk("zero_inputsReady", int'(inputs_ready), 0);
    chk("zero_pixelReady", int'(pixel_ready), 1);
    @(posedge clk); #1;
    chk("zero_emptyFrame_drop", int'(empty_frame), 0);
    send_frame(3, NP);
    chk("after_zero_queueOut", int'(queue_out), 5);
    drain(2000, 1'b0, 1'b0);

    // random frames
    for (int f = 0; f < 2; f++) begin
      send_frame(2, NP);
      drain(2000, 1'b0, 1'b1);
    end

    // reset mid-LOAD
    send_frame(2, 300);
    reset_pulse("midload");
    send_frame(1, NP);
    chk("midload_next_count", int'(active_count), NP);
    drain(NP, 1'b1, 1'b0);

    // reset mid-DRAIN
    send_frame(5, NP);
    chk("middrain_count", int'(active_count), 10);
    chk("middrain_head", int'(queue_out), 3);
    drain(3, 1'b0, 1'b0);
    chk("middrain_after3", int'(active_count), 7);
    chk("middrain_head3", int'(queue_out), 243);
    reset_pulse("middrain");
    send_frame(1, NP);
    drain(NP, 1'b1, 1'b1);
    send_frame(2, NP);
    drain(2000, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
